// File: rtl/systolic_pe_pkg.sv
// Shared types and the saturating/wrapping adder used by the systolic processing element.
package systolic_pe_pkg;

    typedef enum logic {
        MODE_OS = 1'b0,
        MODE_WS = 1'b1
    } mode_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_e;

    // Operands are sign-extended to this width so any result width up to 64 bits fits.
    localparam int SUM_W = 65;

    typedef struct packed {
        logic signed [SUM_W-1:0] sum;
        logic                    ovf;
    } add_res_t;

    function automatic add_res_t sat_wrap_add(
        input logic signed [SUM_W-1:0] a,
        input logic signed [SUM_W-1:0] b,
        input int unsigned             w,
        input bit                      sat
    );
        logic signed [SUM_W-1:0] full;
        logic signed [SUM_W-1:0] hi;
        logic signed [SUM_W-1:0] lo;
        add_res_t                r;
        full  = a + b;
        hi    = (SUM_W'(1) << (w - 1)) - SUM_W'(1);
        lo    = -hi - SUM_W'(1);
        r.ovf = (full > hi) || (full < lo);
        if (sat && (full > hi)) begin
            r.sum = hi;
        end else if (sat && (full < lo)) begin
            r.sum = lo;
        end else begin
            r.sum = full;
        end
        return r;
    endfunction

endpackage

// File: rtl/systolic_pe_sat_add.sv
// Signed adder that either clamps or wraps at WIDTH bits and flags signed overflow.
module sat_add
    import systolic_pe_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b1
) (
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [WIDTH-1:0] sum,
    output logic                    ovf
);

    add_res_t res;
    logic     unused_hi;

    always_comb begin
        res = sat_wrap_add(SUM_W'(a), SUM_W'(b), WIDTH, SATURATE);
        sum = res.sum[WIDTH-1:0];
        ovf = res.ovf;
    end

    // Wrapped results are simply the low WIDTH bits; the extension bits are not needed.
    assign unused_hi = ^res.sum[SUM_W-1:WIDTH];

endmodule

// File: rtl/systolic_pe.sv
// Systolic array processing element: output-stationary MAC with drain chain, or
// weight-stationary partial-sum stage, selected when Clear is asserted.
module systolic_pe
    import systolic_pe_pkg::*;
#(
    parameter int INPUTS_N    = 8,
    parameter int ACCUM_OUT_N = 32,
    parameter bit SATURATE    = 1'b1
) (
    input  logic                          Clock,
    input  logic                          Reset,
    input  logic                          Clear,
    input  logic                          Mode,
    input  logic                          Act_Valid_In,
    input  logic signed [INPUTS_N-1:0]    Act_In,
    input  logic                          Weight_Valid_In,
    input  logic signed [INPUTS_N-1:0]    Weight_In,
    input  logic                          Weight_Load,
    input  logic                          Psum_Valid_In,
    input  logic signed [ACCUM_OUT_N-1:0] Psum_In,
    input  logic                          Drain_Req,
    input  logic                          Drain_Valid_In,
    input  logic                          Drain_Last_In,
    input  logic signed [ACCUM_OUT_N-1:0] Drain_In,
    output logic                          Act_Valid_Out,
    output logic signed [INPUTS_N-1:0]    Act_Out,
    output logic                          Weight_Valid_Out,
    output logic signed [INPUTS_N-1:0]    Weight_Out,
    output logic signed [ACCUM_OUT_N-1:0] Accum_Out,
    output logic                          Psum_Valid_Out,
    output logic signed [ACCUM_OUT_N-1:0] Psum_Out,
    output logic                          Drain_Valid_Out,
    output logic                          Drain_Last_Out,
    output logic signed [ACCUM_OUT_N-1:0] Drain_Out,
    output logic                          Overflow,
    output logic                          Busy
);

    mode_e                           mode;
    state_e                          state;
    logic signed [INPUTS_N-1:0]      w_stat;
    logic signed [INPUTS_N-1:0]      mul_w_p0;
    logic signed [ACCUM_OUT_N-1:0]   psum_p0;
    logic                            vld_p0;
    logic signed [2*INPUTS_N-1:0]    prod_p1;
    logic signed [ACCUM_OUT_N-1:0]   prod_ext;
    logic signed [ACCUM_OUT_N-1:0]   acc_sum;
    logic signed [ACCUM_OUT_N-1:0]   psum_sum;
    logic                            acc_ovf;
    logic                            psum_ovf;
    logic                            os_mac;
    logic                            ws_mac;
    logic                            drain_start;

    // Stage p0: operand pass-through registers and MAC valid
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Act_Valid_Out    <= 1'b0;
            Act_Out          <= '0;
            Weight_Valid_Out <= 1'b0;
            Weight_Out       <= '0;
            vld_p0           <= 1'b0;
            w_stat           <= '0;
            mode             <= MODE_OS;
        end else begin
            Act_Valid_Out    <= Act_Valid_In;
            Act_Out          <= Act_In;
            Weight_Valid_Out <= Weight_Valid_In;
            Weight_Out       <= Weight_In;
            if (mode == MODE_WS && Weight_Load) begin
                w_stat <= Weight_In;
            end
            if (Clear) begin
                mode   <= mode_e'(Mode);
                vld_p0 <= 1'b0;
            end else if (mode == MODE_WS) begin
                vld_p0 <= Act_Valid_In && Psum_Valid_In;
            end else begin
                vld_p0 <= Act_Valid_In && Weight_Valid_In;
            end
        end
    end

    // The old stationary weight is sampled here, so a same-cycle load only affects later activations.
    always_ff @(posedge Clock) begin
        mul_w_p0 <= (mode == MODE_WS) ? w_stat : Weight_In;
        psum_p0  <= Psum_In;
    end

    assign prod_p1     = (2*INPUTS_N)'(Act_Out) * (2*INPUTS_N)'(mul_w_p0);
    assign prod_ext    = ACCUM_OUT_N'(prod_p1);
    assign os_mac      = vld_p0 && (mode == MODE_OS);
    assign ws_mac      = vld_p0 && (mode == MODE_WS);
    assign drain_start = (state == ST_RUN) && (mode == MODE_OS) && Drain_Req;
    assign Busy        = (state == ST_DRAIN);

    sat_add #(.WIDTH(ACCUM_OUT_N), .SATURATE(SATURATE)) u_acc_add (
        .a   (Accum_Out),
        .b   (prod_ext),
        .sum (acc_sum),
        .ovf (acc_ovf)
    );

    sat_add #(.WIDTH(ACCUM_OUT_N), .SATURATE(SATURATE)) u_psum_add (
        .a   (psum_p0),
        .b   (prod_ext),
        .sum (psum_sum),
        .ovf (psum_ovf)
    );

    // Stage p1: accumulator, partial sum and sticky overflow
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Accum_Out      <= '0;
            Overflow       <= 1'b0;
            Psum_Valid_Out <= 1'b0;
            Psum_Out       <= '0;
        end else if (Clear) begin
            Accum_Out      <= '0;
            Overflow       <= 1'b0;
            Psum_Valid_Out <= 1'b0;
        end else begin
            if (drain_start) begin
                Accum_Out <= os_mac ? prod_ext : '0;
            end else if (os_mac) begin
                Accum_Out <= acc_sum;
            end
            Psum_Valid_Out <= ws_mac;
            if (ws_mac) begin
                Psum_Out <= psum_sum;
            end
            if ((os_mac && !drain_start && acc_ovf) || (ws_mac && psum_ovf)) begin
                Overflow <= 1'b1;
            end
        end
    end

    // Drain chain: emit own accumulator once, then forward upstream beats until the last one
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state           <= ST_RUN;
            Drain_Valid_Out <= 1'b0;
            Drain_Last_Out  <= 1'b0;
            Drain_Out       <= '0;
        end else if (Clear) begin
            state           <= ST_RUN;
            Drain_Valid_Out <= 1'b0;
            Drain_Last_Out  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (drain_start) begin
                        Drain_Out       <= Accum_Out;
                        Drain_Valid_Out <= 1'b1;
                        Drain_Last_Out  <= Drain_Last_In;
                        if (!Drain_Last_In) begin
                            state <= ST_DRAIN;
                        end
                    end else begin
                        Drain_Valid_Out <= 1'b0;
                        Drain_Last_Out  <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    Drain_Out       <= Drain_In;
                    Drain_Valid_Out <= Drain_Valid_In;
                    Drain_Last_Out  <= Drain_Valid_In && Drain_Last_In;
                    if (Drain_Valid_In && Drain_Last_In) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_pe.sv
// Bench for systolic_pe: a saturating and a wrapping instance share stimulus and
// are compared every cycle against an arithmetic reference model.
module tb_systolic_pe;

    localparam int IW = 8;
    localparam int AW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, clear, mode_in, act_vld, wgt_vld, weight_load, psum_vld;
    logic drain_req, drain_vld, drain_last;
    logic signed [IW-1:0] act_in, weight_in;
    logic signed [AW-1:0] psum_in, drain_in;

    logic                 avo[2], wvo[2], pvo[2], dvo[2], dlo[2], ovf[2], busy[2];
    logic signed [IW-1:0] ao[2], wo[2];
    logic signed [AW-1:0] acc[2], pso[2], dout[2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        systolic_pe #(.INPUTS_N(IW), .ACCUM_OUT_N(AW), .SATURATE(g == 0)) dut (
            .Clock(clk), .Reset(reset), .Clear(clear), .Mode(mode_in),
            .Act_Valid_In(act_vld), .Act_In(act_in),
            .Weight_Valid_In(wgt_vld), .Weight_In(weight_in), .Weight_Load(weight_load),
            .Psum_Valid_In(psum_vld), .Psum_In(psum_in), .Drain_Req(drain_req),
            .Drain_Valid_In(drain_vld), .Drain_Last_In(drain_last), .Drain_In(drain_in),
            .Act_Valid_Out(avo[g]), .Act_Out(ao[g]),
            .Weight_Valid_Out(wvo[g]), .Weight_Out(wo[g]), .Accum_Out(acc[g]),
            .Psum_Valid_Out(pvo[g]), .Psum_Out(pso[g]),
            .Drain_Valid_Out(dvo[g]), .Drain_Last_Out(dlo[g]), .Drain_Out(dout[g]),
            .Overflow(ovf[g]), .Busy(busy[g])
        );
    end

    // Reference model state (index 0 = saturating, 1 = wrapping)
    bit     m_ws, m_busy, m_dvo, m_dlo, m_psv, m_avo, m_wvo;
    longint m_ao, m_wo, m_wstat;
    longint m_acc[2], m_pso[2], m_dout[2];
    bit     m_ovf[2];
    bit     p_v, p_ws;
    longint p_prod, p_psum;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint fit(longint v, bit sat);
        longint lim  = longint'(1) <<< (AW - 1);
        longint span = lim * 2;
        if (sat) return (v >= lim) ? lim - 1 : ((v < -lim) ? -lim : v);
        return ((((v + lim) % span) + span) % span) - lim;
    endfunction

    function automatic bit oor(longint v);
        longint lim = longint'(1) <<< (AW - 1);
        return (v >= lim) || (v < -lim);
    endfunction

    task automatic model_edge();
        bit     ds, old_ws;
        longint old_w, s;
        if (reset) begin
            m_ws = 0; m_busy = 0; m_dvo = 0; m_dlo = 0; m_psv = 0; m_avo = 0; m_wvo = 0;
            m_ao = 0; m_wo = 0; m_wstat = 0; p_v = 0; p_ws = 0;
            for (int k = 0; k < 2; k++) begin
                m_acc[k] = 0; m_pso[k] = 0; m_dout[k] = 0; m_ovf[k] = 0;
            end
        end else begin
            old_ws = m_ws;
            old_w  = m_wstat;
            m_avo = act_vld; m_ao = act_in; m_wvo = wgt_vld; m_wo = weight_in;
            if (old_ws && weight_load) m_wstat = weight_in;
            if (clear) begin
                m_ws = mode_in; m_busy = 0; m_dvo = 0; m_dlo = 0; m_psv = 0; p_v = 0;
                for (int k = 0; k < 2; k++) begin
                    m_acc[k] = 0; m_ovf[k] = 0;
                end
            end else begin
                ds = !m_busy && !old_ws && drain_req;
                for (int k = 0; k < 2; k++) begin
                    if (ds) begin
                        m_dout[k] = m_acc[k];
                        m_acc[k]  = (p_v && !p_ws) ? p_prod : 0;
                    end else begin
                        if (p_v && !p_ws) begin
                            s = m_acc[k] + p_prod;
                            if (oor(s)) m_ovf[k] = 1;
                            m_acc[k] = fit(s, k == 0);
                        end
                        if (m_busy) m_dout[k] = drain_in;
                    end
                    if (p_v && p_ws) begin
                        s = p_psum + p_prod;
                        if (oor(s)) m_ovf[k] = 1;
                        m_pso[k] = fit(s, k == 0);
                    end
                end
                m_psv = p_v && p_ws;
                if (ds) begin
                    m_dvo = 1; m_dlo = drain_last; m_busy = !drain_last;
                end else if (m_busy) begin
                    m_dvo = drain_vld; m_dlo = drain_vld && drain_last;
                    if (m_dlo) m_busy = 0;
                end else begin
                    m_dvo = 0; m_dlo = 0;
                end
                p_v    = old_ws ? (act_vld && psum_vld) : (act_vld && wgt_vld);
                p_ws   = old_ws;
                p_prod = longint'(act_in) * (old_ws ? old_w : longint'(weight_in));
                p_psum = psum_in;
            end
        end
    endtask

    task automatic compare_all();
        string pfx;
        for (int k = 0; k < 2; k++) begin
            pfx = (k == 0) ? "sat." : "wrap.";
            check({pfx, "act_vld"}, avo[k], m_avo);
            check({pfx, "act"}, ao[k], m_ao);
            check({pfx, "wgt_vld"}, wvo[k], m_wvo);
            check({pfx, "wgt"}, wo[k], m_wo);
            check({pfx, "accum"}, acc[k], m_acc[k]);
            check({pfx, "ovf"}, ovf[k], m_ovf[k]);
            check({pfx, "psum_vld"}, pvo[k], m_psv);
            check({pfx, "psum"}, pso[k], m_pso[k]);
            check({pfx, "drain_vld"}, dvo[k], m_dvo);
            check({pfx, "drain_last"}, dlo[k], m_dlo);
            check({pfx, "drain"}, dout[k], m_dout[k]);
            check({pfx, "busy"}, busy[k], m_busy);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        reset = 0; clear = 0; mode_in = 0; act_vld = 0; wgt_vld = 0; weight_load = 0;
        psum_vld = 0; drain_req = 0; drain_vld = 0; drain_last = 0;
        act_in = '0; weight_in = '0; psum_in = '0; drain_in = '0;
    endtask

    task automatic do_clear(input logic m);
        clear = 1; mode_in = m;
        step();
        clear = 0; mode_in = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        step(); step();
        reset = 0;
        check("rst_accum", acc[0], 0);
        check("rst_busy", busy[0], 0);

        // OS single pair then valid low
        act_in = 5; weight_in = 3; act_vld = 1; wgt_vld = 1;
        step(); check("os_n1", acc[0], 0);
        act_vld = 0; wgt_vld = 0;
        step(); check("os_n2", acc[0], 15);
        step(); check("os_n3", acc[0], 15);
        do_clear(0);

        // OS back-to-back
        act_in = 3; weight_in = 3; act_vld = 1; wgt_vld = 1;
        step();
        act_in = 4; weight_in = 4;
        step(); check("b2b_9", acc[0], 9);
        act_vld = 0; wgt_vld = 0;
        step(); check("b2b_25", acc[0], 25);
        step(); check("b2b_hold", acc[0], 25);
        do_clear(0);

        // Saturation and wrap
        act_in = 127; weight_in = 127; act_vld = 1; wgt_vld = 1;
        repeat (3) step();
        act_vld = 0; wgt_vld = 0;
        step();
        check("sat_clamp", acc[0], 32767);
        check("sat_ovf", ovf[0], 1);
        check("wrap_val", acc[1], -17149);
        check("wrap_ovf", ovf[1], 1);
        do_clear(0);
        check("clr_accum", acc[0], 0);
        check("clr_ovf", ovf[0], 0);

        // WS weight load, partial sum, load concurrent with activation
        do_clear(1);
        weight_load = 1; weight_in = -2;
        step();
        weight_load = 0;
        act_in = 7; act_vld = 1; psum_in = 100; psum_vld = 1;
        step(); check("ws_vld_early", pvo[0], 0);
        act_vld = 0; psum_vld = 0;
        step(); check("ws_psum", pso[0], 86); check("ws_vld", pvo[0], 1);
        step(); check("ws_hold", pso[0], 86); check("ws_vld_low", pvo[0], 0);
        weight_load = 1; weight_in = 5; act_vld = 1; psum_vld = 1;
        step();
        weight_load = 0;
        step(); check("ws_old_w", pso[0], 86);
        act_vld = 0; psum_vld = 0;
        step(); check("ws_new_w", pso[0], 135);
        drain_req = 1;
        step(); check("ws_no_drain", busy[0], 0);
        drain_req = 0;

        // Drain with two upstream beats
        do_clear(0);
        act_in = 23; weight_in = 1; act_vld = 1; wgt_vld = 1;
        step();
        act_vld = 0; wgt_vld = 0;
        step(); check("dr_acc", acc[0], 23);
        drain_req = 1;
        step();
        drain_req = 0;
        check("dr_own", dout[0], 23); check("dr_own_v", dvo[0], 1);
        check("dr_own_l", dlo[0], 0); check("dr_busy", busy[0], 1); check("dr_acc0", acc[0], 0);
        drain_vld = 1; drain_in = 111;
        step(); check("dr_b1", dout[0], 111); check("dr_b1_l", dlo[0], 0);
        drain_in = 222; drain_last = 1;
        step(); check("dr_b2", dout[0], 222); check("dr_b2_l", dlo[0], 1); check("dr_run", busy[0], 0);
        drain_vld = 0; drain_last = 0;
        step(); check("dr_idle_v", dvo[0], 0);

        // Chain head returns to RUN immediately
        act_in = 9; weight_in = 2; act_vld = 1; wgt_vld = 1;
        step();
        act_vld = 0; wgt_vld = 0;
        step();
        drain_req = 1; drain_last = 1;
        step();
        drain_req = 0; drain_last = 0;
        check("head_val", dout[0], 18); check("head_last", dlo[0], 1); check("head_busy", busy[0], 0);

        // Clear concurrent with a valid pair
        act_in = 6; weight_in = 6; act_vld = 1; wgt_vld = 1;
        step();
        act_in = 2; weight_in = 2; clear = 1;
        step();
        clear = 0; act_vld = 0; wgt_vld = 0;
        step(); check("clr_pair", acc[0], 0);

        // Reset during DRAIN
        act_in = 4; weight_in = 4; act_vld = 1; wgt_vld = 1;
        step();
        act_vld = 0; wgt_vld = 0;
        step();
        drain_req = 1;
        step();
        drain_req = 0;
        check("rd_busy", busy[0], 1);
        reset = 1;
        step();
        reset = 0;
        check("rd_busy0", busy[0], 0); check("rd_dvo0", dvo[0], 0);

        // Randomised traffic
        for (int i = 0; i < 800; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            clear       = ($urandom_range(0, 24) == 0);
            mode_in     = 1'($urandom_range(0, 1));
            act_vld     = ($urandom_range(0, 3) != 0);
            wgt_vld     = ($urandom_range(0, 3) != 0);
            psum_vld    = ($urandom_range(0, 2) != 0);
            weight_load = ($urandom_range(0, 4) == 0);
            drain_req   = ($urandom_range(0, 9) == 0);
            drain_vld   = 1'($urandom_range(0, 1));
            drain_last  = ($urandom_range(0, 3) == 0);
            act_in      = IW'($urandom);
            weight_in   = IW'($urandom);
            psum_in     = AW'($urandom);
            drain_in    = AW'($urandom);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
